// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the line-to-word SRAM bridge.
// A line is BEATS words of WORD_W bits; word k of a line sits at bits [32k+31:32k].
package mem_bridge_pkg;

    localparam int unsigned BEATS  = 8;
    localparam int unsigned BEAT_W = 3;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned OFFS_W = 5;  // byte offset bits inside a line

    // Value written into a read lane whose beat was never acknowledged.
    localparam logic [WORD_W-1:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StDone,
        StGuard
    } state_e;

    // Word address of one beat: {line[31:5], beat, 2'b00}.
    function automatic logic [WORD_W-1:0] beat_addr(
        input logic [WORD_W-OFFS_W-1:0] line,
        input logic [BEAT_W-1:0]        beat
    );
        return {line, beat, 2'b00};
    endfunction

endpackage

// File: rtl/mem_bridge_timer.sv
// Per-beat timeout counter. Counts cycles while a beat strobe is up and flags
// expiry on the TIMEOUT-th cycle of the beat; restarts whenever a beat completes.
// Only instantiated when MEM_BRIDGE_TIMEOUT_EN is defined.
module mem_bridge_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active-low
    input  logic run_i,      // beat strobe is high
    input  logic clear_i,    // beat completes this cycle
    output logic expired_o
);

    localparam int unsigned    CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: restart on idle or completed beat, otherwise advance.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || clear_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == CntMax);

endmodule

// File: rtl/mem_line_bridge.sv
// Bridges 256-bit line read/write requests onto a 32-bit word SRAM port as
// eight sequential beats, then pulses ack_o and spends one guard cycle before
// accepting the next request.
// Optional feature: define MEM_BRIDGE_TIMEOUT_EN to add a per-beat timeout
// (TIMEOUT cycles) that force-completes a stalled beat and raises err_o.
module mem_line_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [LINE_W-1:0] data_o,
    input  logic              rd_i,
    input  logic              we_i,
    output logic              ack_o,
    output logic [31:0]       sram_addr_o,
    output logic [31:0]       sram_data_o,
    input  logic [31:0]       sram_data_i,
    output logic              sram_rd_o,
    output logic              sram_we_o,
    input  logic              sram_ack_i
`ifdef MEM_BRIDGE_TIMEOUT_EN
    ,
    output logic              err_o
`endif
);

    localparam int unsigned LineAW = WORD_W - OFFS_W;

    if (TIMEOUT == 0) begin : gen_timeout_chk
        $error("mem_line_bridge: TIMEOUT must be non-zero");
    end

    state_e                         state_q, state_d;
    logic [LineAW-1:0]              line_q, line_d;
    logic [BEAT_W-1:0]              beat_q, beat_d;
    logic [BEATS-1:0][WORD_W-1:0]   wdata_q, wdata_d;
    logic [BEATS-1:0][WORD_W-1:0]   rdata_q, rdata_d;

    logic strobe;
    logic beat_timeout;
    logic beat_adv;

    // Line offset bits of the request address carry no information.
    logic unused_addr_offs;
    assign unused_addr_offs = ^addr_i[OFFS_W-1:0];

    assign strobe   = (state_q == StRead) || (state_q == StWrite);
    assign beat_adv = strobe && (sram_ack_i || beat_timeout);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic expired;
    logic err_q, err_d;

    mem_bridge_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .run_i    (strobe),
        .clear_i  (beat_adv),
        .expired_o(expired)
    );

    // A real ack arriving on the expiry cycle still counts as a good beat.
    assign beat_timeout = expired && !sram_ack_i;

    // Sticky error for the current transaction; dropped at start and in guard.
    always_comb begin
        err_d = err_q;
        if (state_q == StIdle || state_q == StGuard) begin
            err_d = 1'b0;
        end else if (beat_adv && beat_timeout) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = (state_q == StDone) && err_q;
`else
    assign beat_timeout = 1'b0;
`endif

    // Next-state logic: request latch, beat sequencing and read lane capture.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (we_i || rd_i) begin
                    state_d = we_i ? StWrite : StRead;
                    line_d  = addr_i[WORD_W-1:OFFS_W];
                    wdata_d = data_i;
                    beat_d  = '0;
                end
            end
            StRead, StWrite: begin
                if (beat_adv) begin
                    beat_d = beat_q + 1'b1;  // wraps 7 -> 0 on the last beat
                    if (state_q == StRead) begin
                        rdata_d[beat_q] = beat_timeout ? TIMEOUT_FILL : sram_data_i;
                    end
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StGuard;
            StGuard: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            line_q  <= '0;
            beat_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign sram_rd_o   = (state_q == StRead);
    assign sram_we_o   = (state_q == StWrite);
    assign sram_addr_o = beat_addr(line_q, beat_q);
    assign sram_data_o = (state_q == StWrite) ? wdata_q[beat_q] : '0;
    assign ack_o       = (state_q == StDone);
    assign data_o      = rdata_q;

endmodule

// File: tb/tb_mem_line_bridge.sv
// Directed bench for mem_line_bridge: reset values, zero-wait read, stalled
// write with mid-transaction request changes, simultaneous rd/we, reset during
// a read, and the stalled-beat case (timeout with MEM_BRIDGE_TIMEOUT_EN,
// indefinite wait without it).
module tb_mem_line_bridge;
    import mem_bridge_pkg::*;

    localparam int unsigned TIMEOUT = 16;

    logic              clk;
    logic              rst;
    logic [31:0]       addr_i;
    logic [LINE_W-1:0] data_i;
    logic [LINE_W-1:0] data_o;
    logic              rd_i;
    logic              we_i;
    logic              ack_o;
    logic [31:0]       sram_addr_o;
    logic [31:0]       sram_data_o;
    logic [31:0]       sram_data_i;
    logic              sram_rd_o;
    logic              sram_we_o;
    logic              sram_ack_i;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic              err_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // SRAM responder controls: 0 zero-wait, 1 every 3rd cycle, 2 never ack beat 2.
    logic [1:0] ack_mode;
    logic       ack_force;
    logic       ack_gate;
    int         cyc_cnt = 0;

    // Monitor state (written only by the monitor process).
    int          ack_cnt     = 0;
    int          rd_beats    = 0;
    int          we_beats    = 0;
    int          wr_unstable = 0;
    logic [31:0] rd_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] wr_addr_q[$];
    logic        prev_we   = 1'b0;
    logic        prev_ack  = 1'b0;
    logic [31:0] prev_data = '0;

    logic ack_err;

    mem_line_bridge #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .rd_i       (rd_i),
        .we_i       (we_i),
        .ack_o      (ack_o),
        .sram_addr_o(sram_addr_o),
        .sram_data_o(sram_data_o),
        .sram_data_i(sram_data_i),
        .sram_rd_o  (sram_rd_o),
        .sram_we_o  (sram_we_o),
        .sram_ack_i (sram_ack_i)
`ifdef MEM_BRIDGE_TIMEOUT_EN
        ,
        .err_o      (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always_comb begin
        ack_gate = 1'b0;
        case (ack_mode)
            2'd0:    ack_gate = 1'b1;
            2'd1:    ack_gate = ((cyc_cnt % 3) == 2);
            2'd2:    ack_gate = (sram_addr_o[4:2] != 3'd2);
            default: ack_gate = 1'b0;
        endcase
    end

    assign sram_ack_i  = ((sram_rd_o || sram_we_o) && ack_gate) || ack_force;
    assign sram_data_i = sram_addr_o;  // SRAM returns word = its address

    always @(negedge clk) begin
        if (ack_o) ack_cnt <= ack_cnt + 1;
        if (sram_rd_o && sram_ack_i) begin
            rd_beats <= rd_beats + 1;
            rd_addr_q.push_back(sram_addr_o);
        end
        if (sram_we_o && sram_ack_i) begin
            we_beats <= we_beats + 1;
            wr_data_q.push_back(sram_data_o);
            wr_addr_q.push_back(sram_addr_o);
        end
        if (sram_we_o && prev_we && !prev_ack && (sram_data_o != prev_data)) begin
            wr_unstable <= wr_unstable + 1;
        end
        prev_we   <= sram_we_o;
        prev_ack  <= sram_ack_i;
        prev_data <= sram_data_o;
    end

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] act,
                            input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] build_line(input logic [31:0] base,
                                                     input logic [31:0] step);
        logic [BEATS-1:0][WORD_W-1:0] l;
        for (int k = 0; k < BEATS; k++) l[k] = base + step * k;
        return l;
    endfunction

    // Waits for ack_o; lat is the number of rising edges since the request edge.
    task automatic wait_ack(input int budget, output int lat, output logic seen);
        lat     = 0;
        seen    = 1'b0;
        ack_err = 1'b0;
        while (!seen && lat < budget) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (ack_o) begin
                seen = 1'b1;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                ack_err = err_o;
`endif
            end
        end
    endtask

    task automatic do_txn(input logic rd, input logic we, input logic [31:0] addr,
                          input logic [LINE_W-1:0] data, input int budget,
                          output int lat, output logic seen);
        addr_i = addr;
        data_i = data;
        rd_i   = rd;
        we_i   = we;
        wait_ack(budget, lat, seen);
        rd_i = 1'b0;
        we_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int                lat;
        logic              seen;
        logic              found;
        int                ack0, rd0, we0, q0, u0;
        logic [LINE_W-1:0] exp_line;
        logic [LINE_W-1:0] wline;

        rst       = 1'b0;
        rd_i      = 1'b0;
        we_i      = 1'b0;
        addr_i    = '0;
        data_i    = '0;
        ack_mode  = 2'd0;
        ack_force = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ack", ack_o, 0);
        check_eq("rst_sram_rd", sram_rd_o, 0);
        check_eq("rst_sram_we", sram_we_o, 0);
        check_eq("rst_sram_addr", sram_addr_o, 0);
        check_eq("rst_sram_data", sram_data_o, 0);
        check_eq("rst_data_o", data_o, 0);
        rst = 1'b1;
        @(negedge clk);

        // Zero-wait read of 0x1234
        ack0 = ack_cnt; rd0 = rd_beats; we0 = we_beats; q0 = rd_addr_q.size();
        do_txn(1'b1, 1'b0, 32'h0000_1234, '0, 30, lat, seen);
        check_eq("rd_seen", seen, 1);
        check_eq("rd_latency", lat, 9);
        check_eq("rd_ack_pulses", ack_cnt - ack0, 1);
        check_eq("rd_beats", rd_beats - rd0, 8);
        check_eq("rd_we_beats", we_beats - we0, 0);
        for (int k = 0; k < BEATS; k++) begin
            check_eq($sformatf("rd_addr%0d", k), rd_addr_q[q0 + k], 32'h1220 + 4 * k);
        end
        exp_line = build_line(32'h1220, 4);
        check_eq("rd_line", data_o, exp_line);

        // Stray sram_ack_i while idle
        ack0 = ack_cnt;
        ack_force = 1'b1;
        repeat (2) @(negedge clk);
        ack_force = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("stray_ack_no_ack", ack_cnt - ack0, 0);
        check_eq("stray_ack_data", data_o, exp_line);
        check_eq("stray_ack_idle", {sram_rd_o, sram_we_o}, 0);

        // Write with SRAM acking every 3rd cycle; request lines change mid-flight
        ack_mode = 2'd1;
        wline = build_line(32'hA0, 1);
        ack0 = ack_cnt; rd0 = rd_beats; we0 = we_beats; q0 = wr_data_q.size();
        u0 = wr_unstable;
        addr_i = 32'h0000_5A40;
        data_i = wline;
        we_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        we_i   = 1'b0;
        rd_i   = 1'b1;
        data_i = '1;
        addr_i = 32'hFFFF_FFE0;
        wait_ack(100, lat, seen);
        rd_i = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("wr_seen", seen, 1);
        check_eq("wr_beats", we_beats - we0, 8);
        check_eq("wr_rd_beats", rd_beats - rd0, 0);
        check_eq("wr_ack_pulses", ack_cnt - ack0, 1);
        check_eq("wr_stable", wr_unstable - u0, 0);
        for (int k = 0; k < BEATS; k++) begin
            check_eq($sformatf("wr_data%0d", k), wr_data_q[q0 + k], 32'hA0 + k);
            check_eq($sformatf("wr_addr%0d", k), wr_addr_q[q0 + k], 32'h5A40 + 4 * k);
        end
        check_eq("wr_keeps_data_o", data_o, exp_line);

        // rd_i and we_i together: write wins
        ack_mode = 2'd0;
        rd0 = rd_beats; we0 = we_beats; q0 = wr_data_q.size();
        do_txn(1'b1, 1'b1, 32'h0000_0100, build_line(32'hB0, 1), 30, lat, seen);
        check_eq("both_seen", seen, 1);
        check_eq("both_latency", lat, 9);
        check_eq("both_rd_beats", rd_beats - rd0, 0);
        check_eq("both_we_beats", we_beats - we0, 8);
        check_eq("both_last_word", wr_data_q[q0 + 7], 32'hB7);

        // Reset asserted during beat 4 of a read
        addr_i = 32'h0000_4000;
        rd_i   = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sram_rd_o && sram_addr_o[4:2] == 3'd4) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("rst_mid_found_beat4", found, 1);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_sram_rd", sram_rd_o, 0);
        check_eq("rst_mid_sram_we", sram_we_o, 0);
        check_eq("rst_mid_ack", ack_o, 0);
        check_eq("rst_mid_addr", sram_addr_o, 0);
        check_eq("rst_mid_data_o", data_o, 0);
        rd_i = 1'b0;
        ack0 = ack_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("rst_mid_no_ack", ack_cnt - ack0, 0);
        do_txn(1'b1, 1'b0, 32'h0000_8000, '0, 30, lat, seen);
        check_eq("post_rst_seen", seen, 1);
        check_eq("post_rst_latency", lat, 9);
        check_eq("post_rst_line", data_o, build_line(32'h8000, 4));

        // Beat 2 never acknowledged
        ack_mode = 2'd2;
        ack0 = ack_cnt;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        do_txn(1'b1, 1'b0, 32'h0000_2000, '0, 100, lat, seen);
        check_eq("to_seen", seen, 1);
        check_eq("to_latency", lat, 24);
        check_eq("to_err_with_ack", ack_err, 1);
        check_eq("to_lane0", data_o[31:0], 32'h2000);
        check_eq("to_lane2", data_o[95:64], 32'hFFFF_FFFF);
        check_eq("to_lane3", data_o[127:96], 32'h200C);
        check_eq("to_err_cleared", err_o, 0);
`else
        do_txn(1'b1, 1'b0, 32'h0000_2000, '0, 1000, lat, seen);
        check_eq("hang_no_ack", seen, 0);
        check_eq("hang_ack_pulses", ack_cnt - ack0, 0);
        check_eq("hang_strobe", sram_rd_o, 1);
        check_eq("hang_addr", sram_addr_o, 32'h2008);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
`endif

        // Normal read after the stalled case
        ack_mode = 2'd0;
        do_txn(1'b1, 1'b0, 32'h0000_3000, '0, 30, lat, seen);
        check_eq("final_seen", seen, 1);
        check_eq("final_line", data_o, build_line(32'h3000, 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
